// File: rtl/imem_boot_ctrl.sv
// Boot loader and fetch controller for the instruction memory: loads a
// length-prefixed little-endian byte stream, then serves registered fetches.
module imem_boot_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          fetch_fault,
  output logic          core_run,
  output logic          boot_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {HDR0, HDR1, LOAD, RUN, ERR} state_t;

  state_t          state, state_nx;
  logic [15:0]     cnt;
  logic [AW-1:0]   widx;
  logic [1:0]      lane;
  logic [2:0][7:0] asm_q;

  logic        rx_fire, hdr_bad, last_wr, fault, fetch_go;
  logic [15:0] hdr_cnt;

  assign rx_fire  = rx_valid & rx_ready;
  assign hdr_cnt  = {rx_data, cnt[7:0]};
  assign hdr_bad  = (hdr_cnt == 16'd0) || (hdr_cnt > 16'(DEPTH));
  // the final word's write cycle closes the load; no byte is taken during it
  assign last_wr  = mem_we && ({{(16-AW){1'b0}}, mem_waddr} == cnt - 16'd1);
  assign fault    = (|fetch_addr[1:0]) || (fetch_addr[31:2] >= {14'd0, cnt});
  assign fetch_go = (state == RUN) && fetch_req;

  assign rx_ready  = reset && ((state == HDR0) || (state == HDR1) ||
                               ((state == LOAD) && !last_wr));
  assign mem_raddr = (state == RUN) ? fetch_addr[AW+1:2] : '0;
  assign core_run  = (state == RUN);
  assign boot_err  = (state == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HDR0;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR0:    if (rx_fire) state_nx = HDR1;
      HDR1:    if (rx_fire) state_nx = hdr_bad ? ERR : LOAD;
      LOAD:    if (last_wr) state_nx = RUN;
      RUN:     state_nx = RUN;
      ERR:     state_nx = ERR;
      default: state_nx = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      widx        <= '0;
      lane        <= '0;
      asm_q       <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      fetch_instr <= '0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (rx_fire) begin
        case (state)
          HDR0: cnt[7:0] <= rx_data;
          HDR1: begin
            cnt[15:8] <= rx_data;
            widx      <= '0;
            lane      <= '0;
          end
          LOAD: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: asm_q[0] <= rx_data;
              2'd1: asm_q[1] <= rx_data;
              2'd2: asm_q[2] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_waddr <= widx;
                mem_wdata <= {rx_data, asm_q[2], asm_q[1], asm_q[0]};
                widx      <= widx + AW'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
      fetch_valid <= fetch_go;
      fetch_fault <= fetch_go && fault;
      if (fetch_go) fetch_instr <= fault ? NOP : mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: boot loads, fetches, bad headers, resets.
module tb_imem_boot_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic [31:0]   fetch_instr;
  logic          fetch_valid, fetch_fault, core_run, boot_err;

  imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
    .core_run(core_run), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  // instruction memory model plus a log of every write strobe
  logic [31:0] imem [0:DEPTH-1];
  logic [41:0] wlog [0:63];
  int          wr_n = 0;
  assign mem_rdata = imem[mem_raddr];

  always @(posedge clk) begin
    if (mem_we) begin
      imem[mem_waddr] <= mem_wdata;
      if (wr_n < 64) wlog[wr_n] <= {mem_waddr, mem_wdata};
      wr_n <= wr_n + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] ld [0:3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid  = 1'b0;
    fetch_req = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // present one byte from a negedge; returns on the negedge after it transfers
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("rx_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic load(input int n, input bit rnd);
    int base;
    int k;
    base = wr_n;
    send_byte(8'(n), rnd ? int'($urandom_range(0, 2)) : 0);
    send_byte(8'(n >> 8), rnd ? int'($urandom_range(0, 2)) : 0);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(ld[i][8*b +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
        if (!rnd && b == 3) begin
          chk("we_pulse", 32'(mem_we), 32'd1);
          chk("we_addr", 32'(mem_waddr), 32'(i));
          chk("we_data", mem_wdata, ld[i]);
          chk("rdy_in_write", 32'(rx_ready), (i == n - 1) ? 32'd0 : 32'd1);
        end
      end
    end
    if (!rnd) begin
      chk("run_not_yet", 32'(core_run), 32'd0);
      @(negedge clk);
      chk("run_rise", 32'(core_run), 32'd1);
      chk("we_single", 32'(mem_we), 32'd0);
      chk("rdy_run", 32'(rx_ready), 32'd0);
      @(negedge clk);
      rx_valid = 1'b0;
    end else begin
      rx_valid = 1'b0;
      k = 0;
      while (!core_run && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("run_rnd", 32'(core_run), 32'd1);
    end
    chk("wr_count", 32'(wr_n - base), 32'(n));
    for (int i = 0; i < n; i++)
      chk("wr_log", wlog[base + i][31:0], ld[i]);
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [31:0] exp, input logic flt);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("f_valid", 32'(fetch_valid), 32'd1);
    chk("f_instr", fetch_instr, exp);
    chk("f_fault", 32'(fetch_fault), 32'(flt));
    @(negedge clk);
    chk("f_idle", 32'(fetch_valid), 32'd0);
  endtask

  initial begin
    int base;
    // reset values, with stimulus present
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    fetch_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_fvalid", 32'(fetch_valid), 32'd0);
    chk("rst_ffault", 32'(fetch_fault), 32'd0);
    chk("rst_run", 32'(core_run), 32'd0);
    chk("rst_err", 32'(boot_err), 32'd0);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(rx_ready), 32'd1);
    chk("fetch_pre_run", 32'(fetch_valid), 32'd0);
    chk("raddr_pre_run", 32'(mem_raddr), 32'd0);
    fetch_req = 1'b0;

    // N=2 load at full rate
    ld[0] = 32'h00A00513;
    ld[1] = 32'h00B00593;
    load(2, 1'b0);

    // back-to-back fetches
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    @(negedge clk);
    chk("bb0_valid", 32'(fetch_valid), 32'd1);
    chk("bb0_instr", fetch_instr, 32'h00A00513);
    chk("bb0_fault", 32'(fetch_fault), 32'd0);
    fetch_addr = 32'h4;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("bb1_valid", 32'(fetch_valid), 32'd1);
    chk("bb1_instr", fetch_instr, 32'h00B00593);
    chk("bb1_fault", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    chk("bb_idle", 32'(fetch_valid), 32'd0);

    // misaligned and out of range
    fetch1(32'h2, 32'h00000013, 1'b1);
    fetch1(32'h8, 32'h00000013, 1'b1);
    fetch1(32'h8000_0004, 32'h00000013, 1'b1);

    // reset after 6 payload bytes
    do_reset();
    base = wr_n;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0); send_byte(8'h33, 0);
    send_byte(8'h22, 0); send_byte(8'h11, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reset = 1'b0;
    #1;
    chk("mid_rdy", 32'(rx_ready), 32'd0);
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_run", 32'(core_run), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_wr_count", 32'(wr_n - base), 32'd1);
    chk("mid_wr0", 32'(wlog[base]), 32'h11223344);
    ld[0] = 32'hDEADBEEF;
    load(1, 1'b0);
    chk("mid_w1_never", 32'(wlog[base + 1][41:32]), 32'd0);
    fetch1(32'h0, 32'hDEADBEEF, 1'b0);
    // word 1 still holds stale data but lies beyond cnt
    fetch1(32'h4, 32'h00000013, 1'b1);

    // randomly throttled load
    do_reset();
    ld[0] = 32'h12345678;
    ld[1] = 32'h9ABCDEF0;
    ld[2] = 32'h0F1E2D3C;
    load(3, 1'b1);
    fetch1(32'h8, 32'h0F1E2D3C, 1'b0);
    fetch1(32'h4, 32'h9ABCDEF0, 1'b0);
    fetch1(32'hC, 32'h00000013, 1'b1);

    // bad headers: zero and 1025
    for (int h = 0; h < 2; h++) begin
      do_reset();
      base = wr_n;
      send_byte((h == 0) ? 8'h00 : 8'h01, 0);
      send_byte((h == 0) ? 8'h00 : 8'h04, 0);
      chk("err_flag", 32'(boot_err), 32'd1);
      chk("err_rdy", 32'(rx_ready), 32'd0);
      chk("err_run", 32'(core_run), 32'd0);
      rx_data = 8'hFF;
      fetch_req = 1'b1;
      repeat (6) @(negedge clk);
      chk("err_fvalid", 32'(fetch_valid), 32'd0);
      chk("err_no_we", 32'(wr_n - base), 32'd0);
      chk("err_sticky", 32'(boot_err), 32'd1);
      rx_valid = 1'b0;
      fetch_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
